// File: rtl/learn_step_if.sv
// Bus between the learning-mode sequencer and its neighbours: control strobes,
// key levels, note ROM port, tone/hint outputs and score display.
interface learn_step_if #(
    parameter int ADDR_W = 6
);
    logic                start;
    logic                abort;
    logic [3:0]          song_sel;
    logic [6:0]          key_in;
    logic [3+ADDR_W:0]   rom_addr;
    logic [3:0]          rom_data;
    logic [6:0]          led_hint;
    logic                tone_en;
    logic [2:0]          tone_idx;
    logic                hit;
    logic                miss;
    logic [7:0]          hits;
    logic [7:0]          misses;
    logic                busy;
    logic                done;

    modport slave (
        input  start, abort, song_sel, key_in, rom_data,
        output rom_addr, led_hint, tone_en, tone_idx, hit, miss, hits, misses, busy, done
    );

    modport master (
        output start, abort, song_sel, key_in, rom_data,
        input  rom_addr, led_hint, tone_en, tone_idx, hit, miss, hits, misses, busy, done
    );
endinterface

// File: rtl/learn_step_sequencer.sv
// Learning-mode note sequencer: walks a song in the note ROM, hints each key,
// scores the player's press and gates the tone generator on a hit.
module learn_step_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 200000000,
    parameter int TONE_CYC    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    learn_step_if.slave bus
);

    localparam int TMR_MAX = (TIMEOUT_CYC > TONE_CYC) ? TIMEOUT_CYC : TONE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_KEY,
        S_TONE,
        S_RELEASE,
        S_ADVANCE,
        S_DONE
    } state_e;

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  idx_q,      idx_d;
    logic [3:0]         song_q,     song_d;
    logic [2:0]         note_q,     note_d;
    logic [TMR_W-1:0]   tmr_q,      tmr_d;
    logic [6:0]         key_prev_q;
    logic [6:0]         led_hint_q, led_hint_d;
    logic               tone_en_q,  tone_en_d;
    logic [2:0]         tone_idx_q, tone_idx_d;
    logic               hit_q,      hit_d;
    logic               miss_q,     miss_d;
    logic [7:0]         hits_q,     hits_d;
    logic [7:0]         misses_q,   misses_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic               press;
    logic [6:0]         expect_key;

    function automatic logic [6:0] key_onehot(input logic [2:0] note);
        return 7'd1 << (note - 3'd1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A press is the first cycle any key goes down after all keys were up.
    assign press      = (bus.key_in != 7'd0) && (key_prev_q == 7'd0);
    assign expect_key = key_onehot(note_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        song_d   = song_q;
        note_d   = note_q;
        tmr_d    = tmr_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        song_d   = bus.song_sel;
                        idx_d    = '0;
                        hits_d   = 8'd0;
                        misses_d = 8'd0;
                        state_d  = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (bus.rom_data == 4'd0 || bus.rom_data > 4'd7) begin
                        state_d = S_DONE;
                    end else begin
                        note_d  = bus.rom_data[2:0];
                        tmr_d   = '0;
                        state_d = S_WAIT_KEY;
                    end
                end
                S_WAIT_KEY: begin
                    if (press && bus.key_in == expect_key) begin
                        hit_d   = 1'b1;
                        hits_d  = sat_inc(hits_q);
                        tmr_d   = '0;
                        state_d = S_TONE;
                    end else if (press) begin
                        miss_d   = 1'b1;
                        misses_d = sat_inc(misses_q);
                        tmr_d    = tmr_q + 1'b1;
                    end else if (tmr_q >= TMR_W'(TIMEOUT_CYC - 1)) begin
                        // >= so a wrong press landing on the deadline still times out next cycle.
                        miss_d   = 1'b1;
                        misses_d = sat_inc(misses_q);
                        state_d  = S_ADVANCE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_TONE: begin
                    if (tmr_q == TMR_W'(TONE_CYC - 1)) state_d = S_RELEASE;
                    else                               tmr_d   = tmr_q + 1'b1;
                end
                S_RELEASE: begin
                    if (bus.key_in == 7'd0) state_d = S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (idx_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they appear registered with it.
        led_hint_d = (state_d == S_WAIT_KEY || state_d == S_TONE) ? key_onehot(note_d) : 7'd0;
        tone_en_d  = (state_d == S_TONE);
        tone_idx_d = tone_en_d ? note_d : 3'd0;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            song_q     <= 4'd0;
            note_q     <= 3'd0;
            tmr_q      <= '0;
            key_prev_q <= 7'd0;
            led_hint_q <= 7'd0;
            tone_en_q  <= 1'b0;
            tone_idx_q <= 3'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            hits_q     <= 8'd0;
            misses_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every flop samples the pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            song_q     <= song_d;
            note_q     <= note_d;
            tmr_q      <= tmr_d;
            key_prev_q <= bus.key_in;
            led_hint_q <= led_hint_d;
            tone_en_q  <= tone_en_d;
            tone_idx_q <= tone_idx_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr = {song_q, idx_q};
    assign bus.led_hint = led_hint_q;
    assign bus.tone_en  = tone_en_q;
    assign bus.tone_idx = tone_idx_q;
    assign bus.hit      = hit_q;
    assign bus.miss     = miss_q;
    assign bus.hits     = hits_q;
    assign bus.misses   = misses_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_learn_step_sequencer.sv
// Self-checking bench for learn_step_sequencer: plays directed and random songs
// against a note-by-note model of the player/sequencer interaction.
module tb_learn_step_sequencer;

    localparam int ADDR_W      = 3;
    localparam int TIMEOUT_CYC = 20;
    localparam int TONE_CYC    = 5;
    localparam int NOTES       = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    learn_step_if #(.ADDR_W(ADDR_W)) bus ();

    learn_step_sequencer #(
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TONE_CYC   (TONE_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous note ROM: data valid one cycle after the address.
    logic [3:0] rom [0:16*NOTES-1];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int hit_base, miss_base;
    int exp_hits, exp_misses;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.hit)  hit_cnt++;
            if (bus.miss) miss_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [6:0] wrong_key(input logic [6:0] hint);
        logic [6:0] k;
        do k = 7'($urandom_range(1, 127)); while (k == hint);
        return k;
    endfunction

    task automatic start_song(input int s);
        bus.song_sel = 4'(s);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.song_sel = 4'($urandom);
        exp_hits   = 0;
        exp_misses = 0;
        hit_base   = hit_cnt;
        miss_base  = miss_cnt;
        check("start_busy",   bus.busy, 1);
        check("start_done",   bus.done, 0);
        check("start_hits",   bus.hits, 0);
        check("start_misses", bus.misses, 0);
        check("start_addr",   bus.rom_addr, s * NOTES);
    endtask

    // Entered on the first WAIT_KEY sample; leaves on the ADVANCE sample.
    task automatic note_hit(input logic [3:0] code, input int n_wrong, inout bit carried);
        logic [6:0] want, wk;
        int d, extra;
        want = 7'd1 << (code - 4'd1);
        d = $urandom_range(0, 6);
        if (carried && d == 0) d = 1;
        bus.key_in = 7'd0;
        for (int j = 0; j < d; j++) begin
            if (j == 0) begin
                bus.start    = 1'b1;
                bus.song_sel = 4'($urandom);
            end
            tick();
            bus.start = 1'b0;
        end
        carried = 1'b0;
        check("wait_hint", bus.led_hint, want);
        for (int w = 0; w < n_wrong; w++) begin
            wk = wrong_key(want);
            bus.key_in = wk;
            tick();
            exp_misses = sat(exp_misses + 1);
            check("wrong_miss", bus.miss, 1);
            check("wrong_misses", bus.misses, exp_misses);
            check("wrong_hint_held", bus.led_hint, want);
            bus.key_in = 7'd0;
            tick();
            check("miss_one_cycle", bus.miss, 0);
        end
        bus.key_in = want;
        tick();
        exp_hits = sat(exp_hits + 1);
        check("hit_pulse", bus.hit, 1);
        check("hit_tone_en", bus.tone_en, 1);
        check("hit_tone_idx", bus.tone_idx, code);
        check("hit_hits", bus.hits, exp_hits);
        check("tone_hint", bus.led_hint, want);
        for (int t = 1; t < TONE_CYC; t++) begin
            tick();
            check("tone_hold", {bus.tone_en, bus.hit}, 2'b10);
        end
        tick();
        check("release_dark", {bus.tone_en, bus.tone_idx, bus.led_hint}, 11'd0);
        extra = $urandom_range(0, 4);
        repeat (extra) begin
            tick();
            check("release_wait", {bus.busy, bus.tone_en, bus.led_hint}, {1'b1, 1'b0, 7'd0});
        end
        bus.key_in = 7'd0;
        tick();
    endtask

    task automatic note_timeout(input logic [3:0] code, inout bit carried);
        logic [6:0] want;
        bit hold;
        int t;
        want = 7'd1 << (code - 4'd1);
        hold = carried ? 1'b1 : 1'($urandom_range(0, 1));
        t = 0;
        if (!carried && hold) begin
            bus.key_in = wrong_key(want);
            tick();
            exp_misses = sat(exp_misses + 1);
            check("held_wrong_miss", bus.miss, 1);
            t = 1;
        end else if (!carried) begin
            bus.key_in = 7'd0;
        end
        tick(TIMEOUT_CYC - 1 - t);
        check("pre_timeout", {bus.miss, bus.led_hint}, {1'b0, want});
        tick();
        exp_misses = sat(exp_misses + 1);
        check("timeout_miss", bus.miss, 1);
        check("timeout_misses", bus.misses, exp_misses);
        check("timeout_dark", bus.led_hint, 0);
        carried = hold;
    endtask

    // force_act: 0 = clean hit, 1 = wrong press(es) then hit, 2 = timeout, -1 = random.
    task automatic play_song(input int s, input int force_act);
        int n_valid, act;
        logic [3:0] code;
        bit carried;
        n_valid = 0;
        while (n_valid < NOTES && rom[s*NOTES+n_valid] inside {[4'd1:4'd7]}) n_valid++;
        carried = 1'b0;
        start_song(s);
        tick();
        check("lat_load_dark", bus.led_hint, 0);
        tick();
        for (int i = 0; i < n_valid; i++) begin
            code = rom[s*NOTES+i];
            check("note_hint", bus.led_hint, 7'd1 << (code - 4'd1));
            check("note_addr", bus.rom_addr, s * NOTES + i);
            act = (force_act >= 0) ? force_act : $urandom_range(0, 2);
            case (act)
                0:       note_hit(code, 0, carried);
                1:       note_hit(code, $urandom_range(1, 3), carried);
                default: note_timeout(code, carried);
            endcase
            check("advance_state", {bus.busy, bus.tone_en, bus.led_hint}, {1'b1, 1'b0, 7'd0});
            if (i == NOTES - 1) tick();
            else                tick(3);
        end
        check("end_done",   bus.done, 1);
        check("end_busy",   bus.busy, 0);
        check("end_hint",   bus.led_hint, 0);
        check("end_hits",   bus.hits, exp_hits);
        check("end_misses", bus.misses, exp_misses);
        check("hit_pulses", hit_cnt - hit_base, exp_hits);
        check("miss_pulses", miss_cnt - miss_base, exp_misses);
        bus.key_in = 7'd0;
        tick(2);
        check("done_hold", {bus.done, bus.hits}, {1'b1, 8'(exp_hits)});
    endtask

    task automatic rand_rom(input int s);
        for (int j = 0; j < NOTES; j++) rom[s*NOTES+j] = 4'($urandom_range(1, 7));
        if ($urandom_range(0, 2) != 0)
            rom[s*NOTES+$urandom_range(0, NOTES-1)] =
                ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(8, 15));
    endtask

    initial begin
        logic [6:0] hint;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.song_sel = 4'd0;
        bus.key_in   = 7'd0;
        for (int i = 0; i < 16*NOTES; i++) rom[i] = 4'd0;
        rom[0] = 4'd3; rom[1] = 4'd1;
        rom[NOTES] = 4'd5;
        for (int j = 0; j < NOTES; j++) rom[3*NOTES+j] = 4'($urandom_range(1, 7));
        for (int j = 0; j < 4; j++)     rom[4*NOTES+j] = 4'($urandom_range(1, 7));
        rom[2*NOTES] = 4'd4;

        tick(3);
        check("rst_outputs", {bus.led_hint, bus.tone_en, bus.tone_idx, bus.hit, bus.miss},
              13'd0);
        check("rst_counters", {bus.hits, bus.misses}, 16'd0);
        check("rst_status", {bus.busy, bus.done}, 2'b00);
        check("rst_addr", bus.rom_addr, 0);
        @(negedge clk) reset = 1'b0;
        tick();

        play_song(0, 0);
        play_song(1, 1);
        play_song(3, -1);
        play_song(3, 0);
        play_song(4, 2);

        // abort in the middle of a tone
        start_song(2);
        tick(2);
        hint = 7'b0001000;
        check("abort_hint", bus.led_hint, hint);
        bus.key_in = hint;
        tick();
        check("abort_pre_tone", bus.tone_en, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_tone_off", {bus.tone_en, bus.tone_idx, bus.led_hint}, 11'd0);
        check("abort_idle", {bus.busy, bus.done}, 2'b00);
        check("abort_hits_held", bus.hits, 1);
        bus.key_in = 7'd0;
        tick(3);
        check("abort_stays_idle", {bus.busy, bus.led_hint}, 8'd0);

        // async reset while waiting for a key
        start_song(2);
        tick(2);
        check("rst_pre_hint", bus.led_hint, hint);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", {bus.led_hint, bus.busy, bus.tone_en, bus.hit, bus.miss}, 11'd0);
        check("async_rst_addr", bus.rom_addr, 0);
        @(negedge clk) reset = 1'b0;
        tick();

        repeat (12) begin
            int s;
            s = $urandom_range(5, 15);
            rand_rom(s);
            play_song(s, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
